gps_stream_arbiter: RTL and testbench
=====================================

GPS_STREAM_ARBITER -- requirements
Module: gps_stream_arbiter

Interface
REQ-001 SHALL have parameter B, default 8: byte width.
REQ-002 SHALL have parameter MAX_LEN, default 82: maximum sentence length in bytes, NMEA limit.
REQ-003 SHALL have parameter TIMEOUT, default 255: idle cycles before an owned sentence is aborted.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-006 SHALL have port: src_data  input  2*B  byte from source i at [i*B +: B].
REQ-007 SHALL have port: src_valid  input  2  source i presents a byte.
REQ-008 SHALL have port: src_ready  output  2  byte from source i is accepted this cycle when valid and ready are both 1.
REQ-009 SHALL have port: data  output  B  byte to the shared GPS receiver.
REQ-010 SHALL have port: load  output  1  data is valid this cycle; one pulse per forwarded byte.
REQ-011 SHALL have port: owner  output  1  index of the granted source; valid while busy=1.
REQ-012 SHALL have port: busy  output  1  a sentence is currently granted.
REQ-013 SHALL have port: abort  output  1  one-cycle pulse when a sentence is terminated abnormally.

Function
REQ-014 SHALL arbitrate whole sentences: '$' (0x24) starts a sentence and LF (0x0A) ends it.
REQ-015 SHALL use two states, IDLE and BUSY, plus a 1-bit owner register, a 1-bit priority pointer, a length counter and an idle counter.
REQ-016 In IDLE, SHALL drive src_ready=1 for any source presenting a non-'$' byte, and SHALL discard that byte (hunt mode, no load).
REQ-017 In IDLE, a single source presenting '$' SHALL be granted: ready=1, byte accepted, owner set, state to BUSY, length counter set to 1.
REQ-018 In IDLE, when both sources present '$', SHALL grant the source named by the priority pointer; the loser SHALL see src_ready=0 and hold its byte.
REQ-019 In BUSY, SHALL drive src_ready[owner]=1 and src_ready[~owner]=0.
REQ-020 Every accepted granted byte SHALL appear on data with load=1 exactly one cycle after acceptance (registered output, latency 1).
REQ-021 SHALL hold data at its last value and load=0 when no byte was accepted in the previous cycle.
REQ-022 In BUSY, an accepted LF SHALL be forwarded and SHALL return the state to IDLE.
REQ-023 SHALL set the priority pointer to ~owner on every BUSY-to-IDLE transition (round-robin), whether the sentence ended normally or was aborted.
REQ-024 In BUSY, an accepted '$' SHALL be forwarded and SHALL reset the length counter to 1 (resync); owner SHALL NOT change.
REQ-025 In BUSY, each accepted byte SHALL increment the length counter.
REQ-026 If the length counter reaches MAX_LEN on a non-LF byte, SHALL forward that byte, pulse abort, and go to IDLE.
REQ-027 An LF accepted as byte number MAX_LEN SHALL count as a normal end, with no abort.
REQ-028 In BUSY, the idle counter SHALL count consecutive cycles with src_valid[owner]=0 and clear on any accepted byte.
REQ-029 When the idle counter reaches TIMEOUT, SHALL pulse abort and go to IDLE; no byte is forwarded that cycle.
REQ-030 Valid activity on the non-owner SHALL have no effect on the idle counter or on the length counter.
REQ-031 A source may change src_data only after acceptance; the arbiter SHALL NOT depend on a source deasserting src_valid.

Reset
REQ-032 While reset=0, SHALL force: state IDLE, busy=0, owner=0, load=0, abort=0, data=0, priority pointer=0, both counters=0.
REQ-033 While reset=0, src_ready SHALL be 0.
REQ-034 An assertion of reset mid-sentence SHALL discard the sentence with no abort pulse.
REQ-035 After reset release, the first tie SHALL go to source 0.

Verification
REQ-036 Source 0 sends "$GPZDA,143042.00,25,08,2005,,*6E\r\n" → 34 load pulses, data identical to the input and delayed 1 cycle, busy=0 after the LF, abort never asserted.
REQ-037 Both sources present '$' in the same cycle after reset → source 0 is granted and src_ready[1]=0 until source 0's LF; source 1 is then granted; at the next tie, source 0 wins.
REQ-038 Source 1 sends "xx$GP..." in IDLE → 'x','x' are accepted with no load; forwarding starts at '$'.
REQ-039 Owner sends '$' followed by 90 non-LF bytes → exactly 82 loads, one abort pulse on the 82nd, state IDLE, priority pointer flipped.
REQ-040 Owner sends "$GP" then stays silent → abort pulses after 255 idle cycles; the other source's pending '$' is granted the following cycle.
REQ-041 Reset is asserted mid-sentence → outputs clear immediately; after release, fresh '$' from source 1 alone is granted.

Source files
------------

// File: rtl/gps_stream_arbiter.sv
// -----------------------------------------------------------------------------
// gps_stream_arbiter
//
// Merges two NMEA byte streams onto one GPS receiver input, granting whole
// sentences ('$' ... LF) to one source at a time. Ties on '$' are broken by a
// round-robin pointer that flips to the other source whenever a sentence ends.
// Bytes seen while idle that are not '$' are swallowed (hunt mode). A granted
// sentence is cut short if it grows to MAX_LEN bytes without an LF, or if its
// owner goes silent for TIMEOUT consecutive cycles.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low; clears all state, forces src_ready=0
//   src_data    byte from source i at [i*B +: B]
//   src_valid   source i presents a byte
//   src_ready   byte from source i accepted when valid & ready
//   data        forwarded byte, registered (one cycle after acceptance)
//   load        data is valid this cycle
//   owner       granted source index, meaningful while busy=1
//   busy        a sentence is currently granted
//   abort       one-cycle pulse when a sentence is terminated abnormally;
//               for a length overflow it coincides with the load of the last
//               forwarded byte, for a timeout it follows the silent cycle
// -----------------------------------------------------------------------------
module gps_stream_arbiter #(
    parameter int B       = 8,
    parameter int MAX_LEN = 82,   // must be >= 2
    parameter int TIMEOUT = 255   // must be >= 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [2*B-1:0] src_data,
    input  logic [1:0]     src_valid,
    output logic [1:0]     src_ready,
    output logic [B-1:0]   data,
    output logic           load,
    output logic           owner,
    output logic           busy,
    output logic           abort
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [B-1:0]      DOLLAR    = B'(8'h24);
    localparam logic [B-1:0]      LF        = B'(8'h0A);
    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(MAX_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                prio_q,  prio_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [IDLE_W-1:0]   idle_q,  idle_d;
    logic [B-1:0]        data_q,  data_d;
    logic                load_q,  load_d;
    logic                abort_q, abort_d;

    logic [B-1:0]        byte0, byte1, own_byte;
    logic                own_valid;
    logic [1:0]          is_dollar;
    logic [1:0]          ready_c;
    logic                grant_c;

    assign byte0     = src_data[B-1:0];
    assign byte1     = src_data[2*B-1:B];
    assign is_dollar = {src_valid[1] && (byte1 == DOLLAR),
                        src_valid[0] && (byte0 == DOLLAR)};
    assign own_byte  = owner_q ? byte1 : byte0;
    assign own_valid = src_valid[owner_q];

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case below can leave it unassigned (no latch).
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        len_d   = len_q;
        idle_d  = idle_q;
        data_d  = data_q;
        load_d  = 1'b0;
        abort_d = 1'b0;
        ready_c = 2'b00;
        grant_c = prio_q;

        case (state_q)
            IDLE: begin
                // Hunt mode: swallow anything that is not a sentence start.
                ready_c = src_valid & ~is_dollar;
                if (is_dollar != 2'b00) begin
                    grant_c          = (is_dollar == 2'b11) ? prio_q : is_dollar[1];
                    ready_c[grant_c] = 1'b1;
                    owner_d          = grant_c;
                    state_d          = BUSY;
                    len_d            = LEN_W'(1);
                    idle_d           = '0;
                    data_d           = grant_c ? byte1 : byte0;
                    load_d           = 1'b1;
                end
            end

            BUSY: begin
                ready_c[owner_q] = 1'b1;
                if (own_valid) begin
                    data_d = own_byte;
                    load_d = 1'b1;
                    idle_d = '0;
                    if (own_byte == DOLLAR) begin
                        // Resync: a new '$' restarts the sentence, same owner.
                        len_d = LEN_W'(1);
                    end else if (own_byte == LF) begin
                        // LF ends normally even as byte number MAX_LEN.
                        state_d = IDLE;
                        prio_d  = ~owner_q;
                        len_d   = '0;
                    end else if (len_q == LEN_LAST) begin
                        state_d = IDLE;
                        prio_d  = ~owner_q;
                        abort_d = 1'b1;
                        len_d   = '0;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                    abort_d = 1'b1;
                    idle_d  = '0;
                    len_d   = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            len_q   <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            load_q  <= load_d;
            abort_q <= abort_d;
        end
    end

    // ready is combinational from state, so it is gated directly by reset to
    // stay low for the whole time reset is held.
    assign src_ready = ready_c & {2{reset}};
    assign data      = data_q;
    assign load      = load_q;
    assign owner     = owner_q;
    assign busy      = (state_q == BUSY);
    assign abort     = abort_q;

endmodule

// File: tb/tb_gps_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gps_stream_arbiter
//
// Two byte-queue sources feed the arbiter; a sentence-level reference model
// predicts src_ready each cycle and the registered outputs after each edge.
// Directed sentences cover the corner cases, then a randomized run mixes
// sentences, junk, resyncs, overlong sentences and silences.
// -----------------------------------------------------------------------------
module tb_gps_stream_arbiter;

    localparam int B       = 8;
    localparam int MAX_LEN = 82;
    localparam int TIMEOUT = 255;

    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] LF     = 8'h0A;

    logic           clock = 1'b0;
    logic           reset;
    logic [2*B-1:0] src_data;
    logic [1:0]     src_valid;
    logic [1:0]     src_ready;
    logic [B-1:0]   data;
    logic           load;
    logic           owner;
    logic           busy;
    logic           abort;

    gps_stream_arbiter #(
        .B       (B),
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .data      (data),
        .load      (load),
        .owner     (owner),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- sources ----------------
    logic [7:0] srcq [2][$];
    bit         pres  [2];
    logic [7:0] pbyte [2];
    int         pval  [2];
    int         stall [2];

    // ---------------- reference model ----------------
    bit         m_busy;
    int         m_owner, m_rr, m_len, m_idle;
    logic [7:0] m_data;
    bit         m_load, m_abort;

    // observations collected per run
    int n_load, n_abort, g_code, g_count;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rr = 0; m_len = 0; m_idle = 0;
        m_data = 8'h00; m_load = 0; m_abort = 0;
    endtask

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        if (m_busy) return (m_owner == 1) ? 2'b10 : 2'b01;
        r = {pres[1], pres[0]};
        // both starting a sentence: the one not favoured must wait
        if (pres[0] && pres[1] && pbyte[0] == DOLLAR && pbyte[1] == DOLLAR)
            r[1 - m_rr] = 1'b0;
        return r;
    endfunction

    task automatic end_sentence(input bit ab);
        m_busy  = 0;
        m_rr    = 1 - m_owner;
        m_abort = ab;
    endtask

    task automatic model_step(input logic [1:0] acc);
        m_load  = 0;
        m_abort = 0;
        if (!m_busy) begin
            for (int s = 0; s < 2; s++) begin
                if (acc[s] && pbyte[s] == DOLLAR) begin
                    m_busy = 1; m_owner = s; m_len = 1; m_idle = 0;
                    m_data = pbyte[s]; m_load = 1;
                end
            end
        end else if (acc[m_owner]) begin
            m_data = pbyte[m_owner];
            m_load = 1;
            m_idle = 0;
            if (pbyte[m_owner] == DOLLAR) begin
                m_len = 1;
            end else begin
                m_len++;
                if (pbyte[m_owner] == LF)  end_sentence(0);
                else if (m_len == MAX_LEN) end_sentence(1);
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) end_sentence(1);
        end
    endtask

    task automatic push_str(input int s, input string str);
        for (int i = 0; i < str.len(); i++) srcq[s].push_back(str[i]);
    endtask

    task automatic gen_sentence(input int s);
        int body;
        int r;
        if ($urandom_range(99) < 20) push_str(s, "xy");
        srcq[s].push_back(DOLLAR);
        body = $urandom_range(95);
        for (int i = 0; i < body; i++) begin
            r = $urandom_range(99);
            if (r < 2)      srcq[s].push_back(DOLLAR);
            else if (r < 4) srcq[s].push_back(LF);
            else            srcq[s].push_back(8'(8'h41 + $urandom_range(25)));
        end
        if ($urandom_range(99) < 90) srcq[s].push_back(LF);
    endtask

    // Runs checked cycles until both sources drain and the model is idle,
    // or until budget cycles have elapsed.
    task automatic run(input int budget, input bit rnd, input bit expect_drain);
        int         cyc = 0;
        logic [1:0] exp_ready;
        logic [1:0] acc;
        bit         prev_busy = 0;
        n_load = 0; n_abort = 0; g_code = 0; g_count = 0;
        while (1) begin
            if (cyc >= budget) begin
                if (expect_drain)
                    check("drain_pending", srcq[0].size() + srcq[1].size()
                          + int'(pres[0]) + int'(pres[1]) + int'(m_busy), 0);
                break;
            end
            @(negedge clock);
            for (int s = 0; s < 2; s++) begin
                if (!pres[s] && srcq[s].size() > 0) begin
                    if (stall[s] > 0) begin
                        stall[s]--;
                    end else if (rnd && $urandom_range(999) < 3) begin
                        stall[s] = $urandom_range(300);
                    end else if ($urandom_range(99) < pval[s]) begin
                        pres[s]  = 1;
                        pbyte[s] = srcq[s].pop_front();
                    end
                end
            end
            src_valid = {pres[1], pres[0]};
            src_data  = {pbyte[1], pbyte[0]};
            #1;
            exp_ready = model_ready();
            check("src_ready", 32'(src_ready), 32'(exp_ready));
            acc = exp_ready & src_valid;
            model_step(acc);
            @(posedge clock);
            #1;
            check("load",  32'(load),  32'(m_load));
            check("abort", 32'(abort), 32'(m_abort));
            check("busy",  32'(busy),  32'(m_busy));
            check("data",  32'(data),  32'(m_data));
            if (m_busy) check("owner", 32'(owner), 32'(m_owner));
            if (load === 1'b1)  n_load++;
            if (abort === 1'b1) n_abort++;
            if (busy === 1'b1 && !prev_busy) begin
                g_code = g_code * 2 + int'(owner);
                g_count++;
            end
            prev_busy = (busy === 1'b1);
            for (int s = 0; s < 2; s++) if (acc[s]) pres[s] = 0;
            cyc++;
            if (srcq[0].size() == 0 && srcq[1].size() == 0 && !pres[0] && !pres[1] && !m_busy)
                break;
        end
        src_valid = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(src_ready), 0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_owner"}, 32'(owner),     0);
        check({tag, "_load"},  32'(load),      0);
        check({tag, "_abort"}, 32'(abort),     0);
        check({tag, "_data"},  32'(data),      0);
    endtask

    initial begin
        reset     = 1'b0;
        src_valid = 2'b11;
        src_data  = {DOLLAR, DOLLAR};
        pres      = '{0, 0};
        pbyte     = '{8'h00, 8'h00};
        stall     = '{0, 0};
        pval      = '{100, 100};
        model_reset();

        // Reset state, with both sources presenting '$'
        #12;
        check_reset_outputs("rst");
        src_valid = 2'b00;
        @(negedge clock);
        reset = 1'b1;

        // First tie after reset goes to 0, then alternates
        push_str(0, "$GPA,1\n$GPC,3\n");
        push_str(1, "$GPB,2\n$GPD,4\n");
        run(400, 0, 1);
        check("tie_grant_count", g_count, 4);
        check("tie_grant_order", g_code, 4'b0101);

        // Full ZDA sentence from source 0
        push_str(0, "$GPZDA,143042.00,25,08,2005,,*6E\r\n");
        run(400, 0, 1);
        check("zda_loads",  n_load,  34);
        check("zda_aborts", n_abort, 0);

        // Hunt mode: leading junk from source 1 is swallowed
        push_str(1, "xx$GPGLL,1\n");
        run(400, 0, 1);
        check("hunt_loads",  n_load,  9);
        check("hunt_grants", g_count, 1);
        check("hunt_owner",  g_code,  1);

        // Overlong sentence: '$' plus 90 non-LF bytes
        srcq[0].push_back(DOLLAR);
        for (int i = 0; i < 90; i++) srcq[0].push_back(8'h41);
        run(400, 0, 1);
        check("long_loads",  n_load,  MAX_LEN);
        check("long_aborts", n_abort, 1);

        // Pointer flipped by the abort: the next tie goes to source 1
        push_str(0, "$P\n");
        push_str(1, "$Q\n");
        run(400, 0, 1);
        check("post_abort_order", g_code, 2'b10);

        // Owner goes silent; source 1 waits with '$' pending
        push_str(0, "$GP");
        push_str(1, "$GPRMC\n");
        stall[1] = 5;
        run(1000, 0, 1);
        check("silent_aborts", n_abort, 1);
        check("silent_loads",  n_load,  10);
        check("silent_order",  g_code,  2'b01);

        // Reset mid-sentence
        push_str(0, "$GPGGA,123,456\n");
        run(6, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        check_reset_outputs("midrst_hold");
        srcq[0].delete();
        srcq[1].delete();
        pres      = '{0, 0};
        src_valid = 2'b00;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        push_str(1, "$GPRMC,1\n");
        run(400, 0, 1);
        check("after_rst_grants", g_count, 1);
        check("after_rst_owner",  g_code,  1);
        check("after_rst_loads",  n_load,  9);

        // Randomized traffic
        for (int s = 0; s < 2; s++) begin
            pval[s] = 30 + $urandom_range(70);
            for (int k = 0; k < 15; k++) gen_sentence(s);
        end
        run(40000, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
